// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch / operand-fetch / branch sequencer for an SAP-II style
// datapath. Drives the program counter, MAR, memory and IR load controls,
// decodes the control-flow opcodes locally and hands every other opcode to
// the execute controller over an ex_req/ex_done handshake.
//
// Build option: define PCSEQ_CALL_EN to include the return-address stack and
// the CALL/RET instructions. Without it, CALL (0xCD) and RET (0xC9) are
// illegal and drive the sequencer to ERR -> HALT with err set.
//
// state  | meaning
// IDLE   | waiting for run
// F1     | PC onto bus, load MAR
// F2     | increment PC
// F3     | read memory into IR
// DECODE | capture zero flag, branch on opcode
// O1     | PC onto bus, load MAR (operand address)
// O2     | increment PC past operand
// O3     | read operand into tgt
// PUSH   | save return address on stack
// JUMP   | load PC with tgt
// RET    | load PC with top of stack, pop
// EX     | execute controller busy, wait for ex_done
// HALT   | stopped until clr
// ERR    | latch err, then halt
module pc_sequencer #(
    parameter int AW          = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          run,
    input  logic [7:0]    ir,
    input  logic [7:0]    mem_data,
    input  logic [AW-1:0] pc_val,
    input  logic          zero,
    input  logic          ex_done,
    output logic          pc_c,
    output logic          pc_l,
    output logic          pc_e,
    output logic [AW-1:0] pc_load_val,
    output logic          mar_l,
    output logic          mem_ce,
    output logic          ir_l,
    output logic          ex_req,
    output logic          halted,
    output logic          err,
    output logic          busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_F1, S_F2, S_F3, S_DECODE, S_O1, S_O2, S_O3,
        S_PUSH, S_JUMP, S_RET, S_EX, S_HALT, S_ERR
    } state_t;

    typedef enum logic [1:0] {OP_JMP, OP_JZ, OP_JNZ, OP_CALL} op_t;

    localparam int SPW = $clog2(STACK_DEPTH) + 1;

    state_t        state;
    state_t        state_nx;
    op_t           op;
    logic          zq;
    logic [AW-1:0] tgt;

`ifdef PCSEQ_CALL_EN
    logic [AW-1:0]  stack [STACK_DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-2:0] top_idx;
    logic           stack_full;
    logic           stack_empty;
    logic [AW-1:0]  stack_top;

    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    // When full, the low index bits wrap to 0 so minus one still lands on the last entry.
    assign top_idx     = sp[SPW-2:0] - (SPW-1)'(1);
    assign stack_top   = stack[top_idx];

    // Stack pointer: push in PUSH, pop in RET.
    always_ff @(posedge clk) begin
        if (clr) begin
            sp <= '0;
        end else if (state == S_PUSH) begin
            sp <= sp + SPW'(1);
        end else if (state == S_RET) begin
            sp <= sp - SPW'(1);
        end
    end

    // Stack storage; pc_val already points past the CALL operand here.
    always_ff @(posedge clk) begin
        if (!clr && state == S_PUSH) begin
            stack[sp[SPW-2:0]] <= pc_val;
        end
    end
`else
    logic unused_pc_val;
    assign unused_pc_val = ^pc_val;
`endif

    // State register plus the per-instruction context captured along the way.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
            op    <= OP_JMP;
            zq    <= 1'b0;
            tgt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                zq <= zero;
                case (ir)
                    8'hCA:   op <= OP_JZ;
                    8'hC2:   op <= OP_JNZ;
                    8'hCD:   op <= OP_CALL;
                    default: op <= OP_JMP;
                endcase
            end
            if (state == S_O3) begin
                tgt <= AW'(mem_data);
            end
            if (state == S_ERR) begin
                err <= 1'b1;
            end
        end
    end

    // Next-state decode and Moore outputs from the registered state.
    always_comb begin
        state_nx    = state;
        pc_c        = 1'b0;
        pc_l        = 1'b0;
        pc_e        = 1'b0;
        pc_load_val = '0;
        mar_l       = 1'b0;
        mem_ce      = 1'b0;
        ir_l        = 1'b0;
        ex_req      = 1'b0;
        halted      = 1'b0;
        busy        = (state != S_IDLE) && (state != S_HALT);
        case (state)
            S_IDLE: begin
                if (run) state_nx = S_F1;
            end
            S_F1: begin
                pc_e     = 1'b1;
                mar_l    = 1'b1;
                state_nx = S_F2;
            end
            S_F2: begin
                pc_c     = 1'b1;
                state_nx = S_F3;
            end
            S_F3: begin
                mem_ce   = 1'b1;
                ir_l     = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                case (ir)
                    8'h00:               state_nx = S_F1;
                    8'h76:               state_nx = S_HALT;
                    8'hC3, 8'hCA, 8'hC2: state_nx = S_O1;
`ifdef PCSEQ_CALL_EN
                    8'hCD:               state_nx = S_O1;
                    8'hC9:               state_nx = stack_empty ? S_ERR : S_RET;
`else
                    8'hCD, 8'hC9:        state_nx = S_ERR;
`endif
                    default:             state_nx = S_EX;
                endcase
            end
            S_O1: begin
                pc_e     = 1'b1;
                mar_l    = 1'b1;
                state_nx = S_O2;
            end
            S_O2: begin
                pc_c     = 1'b1;
                state_nx = S_O3;
            end
            S_O3: begin
                mem_ce = 1'b1;
                case (op)
                    OP_JZ:   state_nx = zq ? S_JUMP : S_F1;
                    OP_JNZ:  state_nx = zq ? S_F1 : S_JUMP;
`ifdef PCSEQ_CALL_EN
                    OP_CALL: state_nx = stack_full ? S_ERR : S_PUSH;
`else
                    OP_CALL: state_nx = S_ERR;
`endif
                    default: state_nx = S_JUMP;
                endcase
            end
            S_PUSH: begin
                state_nx = S_JUMP;
            end
            S_JUMP: begin
                pc_l        = 1'b1;
                pc_load_val = tgt;
                state_nx    = S_F1;
            end
            S_RET: begin
                pc_l     = 1'b1;
`ifdef PCSEQ_CALL_EN
                pc_load_val = stack_top;
`endif
                state_nx = S_F1;
            end
            S_EX: begin
                ex_req = 1'b1;
                if (ex_done) state_nx = S_F1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERR: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models PC counter, MAR, memory and IR around the
// sequencer. The driver queues expected events (instruction fetch address,
// PC loads, execute-request cycles, halt status) with their cycle numbers
// counted from the run pulse; a separate monitor pops and compares them.
module tb_pc_sequencer;

    localparam int EV_FETCH = 0;
    localparam int EV_LOAD  = 1;
    localparam int EV_EX    = 2;
    localparam int EV_HALT  = 3;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       run = 1'b0;
    logic       zero = 1'b0;
    logic       ex_done = 1'b0;
    logic [7:0] ir_reg;
    logic [7:0] mar;
    logic [7:0] pc;
    logic [7:0] mem_data;
    logic [7:0] mem [256];

    logic       pc_c, pc_l, pc_e, mar_l, mem_ce, ir_l, ex_req, halted, err, busy;
    logic [7:0] pc_load_val;

    ev_t exp_q[$];
    int  cyc_abs = 0;
    int  t0 = 0;
    int  n_pass = 0;
    int  n_total = 0;
    bit  mon_en = 0;
    bit  chk_idle = 0;
    int  end_req = 0;

    pc_sequencer #(.AW(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir_reg), .mem_data(mem_data),
        .pc_val(pc), .zero(zero), .ex_done(ex_done),
        .pc_c(pc_c), .pc_l(pc_l), .pc_e(pc_e), .pc_load_val(pc_load_val),
        .mar_l(mar_l), .mem_ce(mem_ce), .ir_l(ir_l), .ex_req(ex_req),
        .halted(halted), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_data = mem[mar];

    // Datapath model: program counter, MAR and IR.
    always @(posedge clk) begin
        cyc_abs <= cyc_abs + 1;
        if (clr) begin
            pc     <= 8'h00;
            mar    <= 8'h00;
            ir_reg <= 8'h00;
        end else begin
            if (pc_l)      pc <= pc_load_val;
            else if (pc_c) pc <= pc + 8'h01;
            if (mar_l)     mar <= pc;
            if (ir_l)      ir_reg <= mem_data;
        end
    end

    task automatic chk(input string name, input bit ok, input int act, input int exp_v);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    endtask

    task automatic ev(input int kind, input int val, input int k);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected event kind %0d val %0h at cycle %0d", kind, val, k);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.val == val && e.cyc == k) n_pass++;
            else $display("FAIL event: got kind %0d val %0h cycle %0d, expected kind %0d val %0h cycle %0d",
                          kind, val, k, e.kind, e.val, e.cyc);
        end
    endtask

    // Monitor: samples on the falling edge and checks against the queue.
    initial begin
        int  k;
        int  end_seen;
        bit  halted_q;
        end_seen = 0;
        halted_q = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                k = cyc_abs - t0;
                chk("pc_ctl_onehot", $countones({pc_c, pc_l, pc_e}) <= 1, int'({pc_c, pc_l, pc_e}), 0);
                if (chk_idle)
                    chk("idle_outputs",
                        {pc_c, pc_l, pc_e, pc_load_val, mar_l, mem_ce, ir_l, ex_req, halted, err, busy} == '0,
                        int'({pc_c, pc_l, pc_e, pc_load_val, mar_l, mem_ce, ir_l, ex_req, halted, err, busy}), 0);
                if (ir_l)   ev(EV_FETCH, int'(mar), k);
                if (pc_l)   ev(EV_LOAD, int'(pc_load_val), k);
                if (ex_req) ev(EV_EX, 0, k);
                if (halted && !halted_q) ev(EV_HALT, int'({err, pc}), k);
                halted_q = halted;
                if (end_req != end_seen) begin
                    chk("events_left", exp_q.size() == 0, exp_q.size(), 0);
                    exp_q.delete();
                    end_seen = end_req;
                end
            end
        end
    end

    function automatic void expect_ev(input int kind, input int val, input int cyc);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endfunction

    task automatic reset_dut();
        @(posedge clk);
        #1 clr = 1'b1;
        run = 1'b0;
        ex_done = 1'b0;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h76;
    endtask

    // Cycle 1 is the first F1 cycle after the run pulse.
    task automatic start();
        @(posedge clk);
        #1 t0 = cyc_abs;
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 150; i++) begin
            if (halted) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1 end_req++;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] br_op   [5] = '{8'hCA, 8'hC2, 8'hCA, 8'hC2, 8'hC3};
    logic       br_zero [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bit         br_take [5] = '{0, 1, 1, 0, 1};

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        mon_en = 1'b1;
        chk_idle = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk_idle = 1'b0;

        // NOP then HLT
        reset_dut();
        mem[0] = 8'h00; mem[1] = 8'h76;
        expect_ev(EV_FETCH, 8'h00, 3);
        expect_ev(EV_FETCH, 8'h01, 7);
        expect_ev(EV_HALT, 8'h02, 9);
        start();
        wait_done();

        // Branches: JZ/JNZ/JMP, target 0x20+0x10*i
        for (int i = 0; i < 5; i++) begin
            reset_dut();
            zero = br_zero[i];
            mem[0] = br_op[i];
            mem[1] = 8'h20 + 8'(i * 16);
            expect_ev(EV_FETCH, 0, 3);
            if (br_take[i]) begin
                expect_ev(EV_LOAD, 8'h20 + i * 16, 8);
                expect_ev(EV_FETCH, 8'h20 + i * 16, 11);
                expect_ev(EV_HALT, 8'h21 + i * 16, 13);
            end else begin
                expect_ev(EV_FETCH, 2, 10);
                expect_ev(EV_HALT, 3, 12);
            end
            start();
            wait_done();
        end

        // CALL 0x40, RET back to 0x02, then RET on the now-empty stack
        reset_dut();
        mem[0] = 8'hCD; mem[1] = 8'h40; mem[2] = 8'hC9; mem[8'h40] = 8'hC9;
        expect_ev(EV_FETCH, 0, 3);
`ifdef PCSEQ_CALL_EN
        expect_ev(EV_LOAD, 8'h40, 9);
        expect_ev(EV_FETCH, 8'h40, 12);
        expect_ev(EV_LOAD, 8'h02, 14);
        expect_ev(EV_FETCH, 8'h02, 17);
        expect_ev(EV_HALT, 256 + 3, 20);
`else
        expect_ev(EV_HALT, 256 + 1, 6);
`endif
        start();
        wait_done();

        // Five nested CALLs against a four-entry stack
        reset_dut();
        for (int n = 0; n < 5; n++) begin
            mem[n * 16]     = 8'hCD;
            mem[n * 16 + 1] = 8'((n + 1) * 16);
        end
        expect_ev(EV_FETCH, 0, 3);
`ifdef PCSEQ_CALL_EN
        expect_ev(EV_LOAD, 8'h10, 9);
        for (int n = 1; n < 4; n++) begin
            expect_ev(EV_FETCH, n * 16, 9 * n + 3);
            expect_ev(EV_LOAD, (n + 1) * 16, 9 * n + 9);
        end
        expect_ev(EV_FETCH, 8'h40, 39);
        expect_ev(EV_HALT, 256 + 8'h42, 45);
`else
        expect_ev(EV_HALT, 256 + 1, 6);
`endif
        start();
        wait_done();

        // RET with empty stack
        reset_dut();
        mem[0] = 8'hC9;
        expect_ev(EV_FETCH, 0, 3);
        expect_ev(EV_HALT, 256 + 1, 6);
        start();
        wait_done();

        // Generic opcode, ex_done after 3 EX cycles; stray ex_done in F2 ignored
        reset_dut();
        mem[0] = 8'h80; mem[1] = 8'h76;
        expect_ev(EV_FETCH, 0, 3);
        expect_ev(EV_EX, 0, 5);
        expect_ev(EV_EX, 0, 6);
        expect_ev(EV_EX, 0, 7);
        expect_ev(EV_FETCH, 1, 10);
        expect_ev(EV_HALT, 2, 12);
        start();
        @(posedge clk);
        #1 ex_done = 1'b1;
        @(posedge clk);
        #1 ex_done = 1'b0;
        repeat (4) @(posedge clk);
        #1 ex_done = 1'b1;
        @(posedge clk);
        #1 ex_done = 1'b0;
        wait_done();

        // Generic opcode with ex_done already high: one EX cycle
        reset_dut();
        mem[0] = 8'h80; mem[1] = 8'h76;
        ex_done = 1'b1;
        expect_ev(EV_FETCH, 0, 3);
        expect_ev(EV_EX, 0, 5);
        expect_ev(EV_FETCH, 1, 8);
        expect_ev(EV_HALT, 2, 10);
        start();
        wait_done();
        ex_done = 1'b0;

        // clr during O2 of a JMP: idle next cycle, no further PC pulses
        reset_dut();
        mem[0] = 8'hC3; mem[1] = 8'h20;
        expect_ev(EV_FETCH, 0, 3);
        start();
        repeat (5) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        chk_idle = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk_idle = 1'b0;
        end_req++;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller that sequences the 8-bit program counter, memory address register, memory and instruction register through SAP-II style fetch, operand-fetch and branch cycles. It drives the counter's count/load/enable controls and load value, and decodes control-flow opcodes (JMP, JZ, JNZ, CALL, RET, HLT, NOP) itself. All other opcodes go to the execute controller through a req/done handshake. An internal return-address stack supports CALL/RET.

## Interface
- `AW`, 8: address / PC width.
- `STACK_DEPTH`, 4: return-stack entries (power of two, ≥2).

- `clk`  in  1: single clock, all state updates on posedge.
- `clr`  in  1: reset, synchronous, active-high.
- `run`  in  1: start fetching; sampled only in IDLE.
- `ir`  in  8: opcode from instruction register; valid from DECODE onward.
- `mem_data`  in  8: memory read data; sampled in O3.
- `pc_val`  in  AW: current PC count.
- `zero`  in  1: ALU zero flag; sampled in DECODE.
- `ex_done`  in  1: execute controller finished.
- `pc_c`  out  1: PC increment.
- `pc_l`  out  1: PC load.
- `pc_e`  out  1: PC bus enable.
- `pc_load_val`  out  AW: PC load value; meaningful only when `pc_l`=1.
- `mar_l`  out  1: MAR load.
- `mem_ce`  out  1: memory read enable.
- `ir_l`  out  1: IR load.
- `ex_req`  out  1: execute request.
- `halted`  out  1: in HALT.
- `err`  out  1: sticky stack fault / illegal-op flag.
- `busy`  out  1: not in IDLE/HALT.

## Operation
- Moore FSM. All control outputs are decoded from the registered state and are 1 only in the states listed.
- States and outputs:
  - IDLE: outputs 0. `run`=1 → F1.
  - F1: `pc_e`, `mar_l`.
  - F2: `pc_c`.
  - F3: `mem_ce`, `ir_l`.
  - DECODE: register `zero` into `zq`, then branch on `ir`.
- Decode targets:
  - 0x00 NOP → F1.
  - 0x76 HLT → HALT.
  - 0xC3 JMP, 0xCA JZ, 0xC2 JNZ, 0xCD CALL → O1.
  - 0xC9 RET → RET if stack not empty, else ERR.
  - Any other opcode → EX.
- Operand fetch:
  - O1: `pc_e`, `mar_l`.
  - O2: `pc_c`.
  - O3: `mem_ce`; `tgt`←`mem_data`.
- After O3:
  - JMP → JUMP.
  - JZ → JUMP if `zq`=1, else F1.
  - JNZ → JUMP if `zq`=0, else F1.
  - CALL → PUSH if stack not full, else ERR.
- PUSH: `stack[sp]`←`pc_val` (already the return address, past the operand); `sp`+1 → JUMP.
- JUMP: `pc_l`=1, `pc_load_val`=`tgt` → F1.
- RET: `pc_l`=1, `pc_load_val`=`stack[sp-1]`; `sp`−1 → F1.
- EX: `ex_req`=1, held until `ex_done`=1 is sampled; then → F1. `ex_done` outside EX is ignored.
- HALT: `halted`=1; leaves only on `clr`.
- ERR: `err`←1, then → HALT.
- Width rules:
  - `tgt` zero-extended to AW.
  - `sp` is log2(STACK_DEPTH)+1 bits; full when `sp`=STACK_DEPTH, empty when 0.
  - PC wrap (0xFF→0x00) belongs to the counter and is not checked here.

## Timing
- `clr` wins over everything. Next cycle: state=IDLE, `sp`=0, `err`=0, `tgt`=0, `zq`=0, and all outputs 0 (`pc_load_val`=0).
- `clr` mid-instruction aborts it with no further PC control pulses.
- `run` → F1 on the following cycle.
- Instruction lengths (cycles):
  - NOP: 4 (F1–F3, DECODE).
  - Not-taken JZ/JNZ: 7.
  - JMP / taken branch: 8.
  - CALL: 9.
  - RET: 5.
  - Generic opcode: 5 + cycles until `ex_done`.
- `ex_done` high in the first EX cycle → EX lasts exactly one cycle.
- At most one of `pc_c`/`pc_l`/`pc_e` is high in any cycle.
- `ir` and `mem_data` are sampled only in the states named above.

## Configuration
- `PCSEQ_CALL_EN` defined: return stack, PUSH and RET states, and CALL/RET decode compiled in.
- Undefined: no stack storage. 0xCD and 0xC9 decode as illegal → ERR → HALT with `err`=1.

## Test plan
- Reset/idle: `clr`=1 for 2 cycles, then `run`=0 → all outputs 0, `busy`=0, and nothing changes for 10 cycles.
- Fetch: memory 0x00 NOP, 0x01 HLT; `run` pulse → `pc_e`+`mar_l`, `pc_c`, `mem_ce`+`ir_l` pulses twice, then `halted`=1 with PC=0x02.
- Branches: JZ 0x20 with `zero`=0 → falls through to 0x02. JNZ 0x20 with `zero`=0 → `pc_l` with `pc_load_val`=0x20 in cycle 8.
- Call/return: CALL 0x40 at 0x00 pushes 0x02; RET at 0x40 → `pc_load_val`=0x02, `sp` back to 0.
- Stack faults: 5 nested CALLs with depth 4 → `err`=1 and `halted`=1 after the 5th operand read. RET with empty stack → `err`=1.
- Handshake/reset: opcode 0x80 → `ex_req` held 3 cycles until `ex_done`. `clr` asserted during O2 → IDLE next cycle with no `pc_c`. Rebuild without `PCSEQ_CALL_EN` → CALL sets `err`.
